dma_dev_agent: RTL and testbench
================================

Name: dma_dev_agent

Overview:
Device-side DMA initiator that drives the device interface of dma_controller: requester on one side, data source/sink on the other. A host-side register/buffer port lets local logic load a small word buffer, program a descriptor (direction, word count, logical byte address) and pulse start. The agent issues the request, streams words with the dev_ack/dma_ack handshake, checks completion against end_flag, and reports done/error.

Parameters:
ADD_LEN, 16, physical word-address width; start_addr output is ADD_LEN+1 bits (logical byte address).
DATA_LEN, 16, data word width.
BUF_AW, 5, local buffer address width; BUF_DEPTH = 2^BUF_AW words.
TIMEOUT_W, 12, watchdog width; expiry when counter reaches all-ones.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
host_start  in  1  one-cycle start pulse; ignored while busy
host_dir  in  1  1 = memory->device (read), 0 = device->memory (write)
host_words  in  ADD_LEN  word count
host_addr  in  ADD_LEN+1  logical byte start address
buf_we  in  1  host buffer write strobe; ignored while busy
buf_addr  in  BUF_AW  host buffer address
buf_wdata  in  DATA_LEN  host write data
buf_rdata  out  DATA_LEN  combinational read of buf[buf_addr]
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer (success or error)
err  out  1  error status, held until next accepted start
err_code  out  2  0 none, 1 bad length, 2 timeout, 3 count mismatch
dev_ready  in  1  local device can accept/supply data (back-pressure)
num_words  out  ADD_LEN  to controller
start_addr  out  ADD_LEN+1  to controller
rd_wr  out  1  to controller
rqst  out  1  to controller
dev_ack  out  1  to controller
dev_in  out  DATA_LEN  to controller (write data)
dma_ack  in  1  from controller; data beat valid
dev_out  in  DATA_LEN  from controller (read data)
end_flag  in  1  from controller; transfer complete

Behaviour:
- Reset: state IDLE; all outputs 0; ptr, beat counter, watchdog cleared; buffer contents undefined.
- States: IDLE, REQ, XFER, DONE, ERR.
- IDLE: on host_start, latch descriptor into num_words/start_addr/rd_wr; clear err/err_code. If host_words==0 or > BUF_DEPTH -> ERR with code 1, no rqst issued. Else -> REQ.
- REQ: rqst=1 for exactly one cycle -> XFER. Descriptor outputs stay stable from REQ until return to IDLE.
- XFER: busy=1; dev_ack = dev_ready. dev_in = buf[ptr] (combinational).
  - Each cycle with dma_ack=1: if rd_wr, buf[ptr] <= dev_out; ptr++; beats++. Watchdog cleared.
  - Beats beyond num_words: data discarded, ptr frozen, mismatch recorded.
  - end_flag=1 -> DONE if beats==num_words and no overflow, else ERR code 3. A dma_ack in the same cycle as end_flag counts first.
  - Watchdog increments each cycle without dma_ack or end_flag; at all-ones -> ERR code 2; dev_ack drops immediately.
- DONE: done=1 one cycle -> IDLE.
- ERR: done=1, err=1 (held) one cycle -> IDLE.
- busy=1 in REQ, XFER, DONE, ERR.
- host_start while busy: ignored. buf_we while busy: ignored. buf_rdata always valid.
- ptr width BUF_AW; beats width ADD_LEN; ptr reset to 0 on each accepted start.
- Reset mid-operation: immediate return to IDLE, rqst/dev_ack low within same cycle; no done pulse.

Decomposition:
- Package dma_agent_pkg: state encoding constants, err_code constants (ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_COUNT).
- Sub-module dma_agent_buf: register array, one sync write port muxed host/DMA by busy, two async read ports (host, ptr).

Test Plan:
- Write: buffer 0x1111,0x2222,0x3333,0x4444; start dir=0, words=4, addr=0x0200 -> one rqst pulse, start_addr=0x0200, dev_in steps through values per dma_ack, done after end_flag, err=0.
- Read with stall: words=3, controller beats 0xA0A0,0xB0B0,0xC0C0; dev_ready low 2 cycles mid-stream -> dev_ack low then, buffer holds all three in order, done.
- Bad length: words=0 and words=33 -> no rqst, done pulse, err_code=1.
- Timeout: words=2, controller silent -> after 4095 idle cycles err_code=2, dev_ack low.
- Mismatch: words=4, end_flag after 2 beats -> err_code=3; 5 beats then end_flag -> err_code=3, fifth word not stored.
- Reset mid-XFER after 1 beat -> all outputs 0 next cycle, no done; new start then proceeds normally.

Source files
------------

// File: rtl/dma_agent_pkg.sv
// dma_dev_agent shared types.
// FSM encoding and error codes.
package dma_agent_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_COUNT   = 2'd3;

endpackage

// File: rtl/dma_agent_buf.sv
// Word buffer: one write port shared host/DMA,
// two async read ports.
module dma_agent_buf
  import dma_agent_pkg::*;
#(
  parameter int DATA_LEN = 16,
  parameter int BUF_AW   = 5
) (
  input  logic                clk,
  input  logic                busy,
  input  logic                host_we,
  input  logic [BUF_AW-1:0]   host_addr,
  input  logic [DATA_LEN-1:0] host_wdata,
  output logic [DATA_LEN-1:0] host_rdata,
  input  logic                dma_we,
  input  logic [BUF_AW-1:0]   dma_ptr,
  input  logic [DATA_LEN-1:0] dma_wdata,
  output logic [DATA_LEN-1:0] dma_rdata
);

  localparam int BUF_DEPTH = 1 << BUF_AW;

  logic [DATA_LEN-1:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (busy) begin
      if (dma_we) mem[dma_ptr] <= dma_wdata;
    end else if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  assign host_rdata = mem[host_addr];
  assign dma_rdata  = mem[dma_ptr];

endmodule

// File: rtl/dma_dev_agent.sv
// Device-side DMA initiator: descriptor,
// request, beat streaming, completion check.
module dma_dev_agent
  import dma_agent_pkg::*;
#(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int BUF_AW    = 5,
  parameter int TIMEOUT_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_start,
  input  logic                host_dir,
  input  logic [ADD_LEN-1:0]  host_words,
  input  logic [ADD_LEN:0]    host_addr,
  input  logic                buf_we,
  input  logic [BUF_AW-1:0]   buf_addr,
  input  logic [DATA_LEN-1:0] buf_wdata,
  output logic [DATA_LEN-1:0] buf_rdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  input  logic                dev_ready,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                rd_wr,
  output logic                rqst,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                end_flag
);

  localparam int BUF_DEPTH = 1 << BUF_AW;
  localparam logic [ADD_LEN-1:0] DEPTH_W =
    ADD_LEN'(BUF_DEPTH);
  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state;
  logic [BUF_AW-1:0]    ptr;
  logic [ADD_LEN-1:0]   beats;
  logic                 ovf;
  logic [TIMEOUT_W-1:0] wd;

  logic                 in_xfer;
  logic                 beat_ok;
  logic                 beat_ovf;
  logic [ADD_LEN-1:0]   beats_nxt;
  logic                 ovf_nxt;
  logic                 count_ok;
  logic                 bad_len;
  logic [DATA_LEN-1:0]  dma_rdata;

  assign in_xfer   = (state == S_XFER);
  assign beat_ok   = in_xfer && dma_ack &&
                     (beats < num_words);
  assign beat_ovf  = in_xfer && dma_ack &&
                     !(beats < num_words);
  // A beat in the end_flag cycle is counted first.
  assign beats_nxt = beats + ADD_LEN'(beat_ok);
  assign ovf_nxt   = ovf | beat_ovf;
  assign count_ok  = (beats_nxt == num_words) &&
                     !ovf_nxt;
  assign bad_len   = (host_words == '0) ||
                     (host_words > DEPTH_W);

  assign dev_ack = in_xfer && dev_ready;
  assign dev_in  = in_xfer ? dma_rdata : '0;

  dma_agent_buf #(
    .DATA_LEN (DATA_LEN),
    .BUF_AW   (BUF_AW)
  ) u_buf (
    .clk        (clk),
    .busy       (busy),
    .host_we    (buf_we),
    .host_addr  (buf_addr),
    .host_wdata (buf_wdata),
    .host_rdata (buf_rdata),
    .dma_we     (beat_ok && rd_wr),
    .dma_ptr    (ptr),
    .dma_wdata  (dev_out),
    .dma_rdata  (dma_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      beats      <= '0;
      ovf        <= 1'b0;
      wd         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      num_words  <= '0;
      start_addr <= '0;
      rd_wr      <= 1'b0;
      rqst       <= 1'b0;
    end else begin
      rqst <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (host_start) begin
            num_words  <= host_words;
            start_addr <= host_addr;
            rd_wr      <= host_dir;
            ptr        <= '0;
            beats      <= '0;
            ovf        <= 1'b0;
            wd         <= '0;
            busy       <= 1'b1;
            if (bad_len) begin
              state    <= S_ERR;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              state    <= S_REQ;
              rqst     <= 1'b1;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end
          end
        end
        S_REQ: state <= S_XFER;
        S_XFER: begin
          if (beat_ok) ptr <= ptr + BUF_AW'(1);
          beats <= beats_nxt;
          ovf   <= ovf_nxt;
          if (end_flag) begin
            done <= 1'b1;
            wd   <= '0;
            if (count_ok) begin
              state <= S_DONE;
            end else begin
              state    <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_COUNT;
            end
          end else if (dma_ack) begin
            wd <= '0;
          end else if (wd == WD_LAST) begin
            state    <= S_ERR;
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end else begin
            wd <= wd + TIMEOUT_W'(1);
          end
        end
        S_DONE, S_ERR: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_dev_agent.sv
// Directed bench for dma_dev_agent: transfer
// table plus stall, timeout and reset sequences.
module tb_dma_dev_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_start;
  logic        host_dir;
  logic [15:0] host_words;
  logic [16:0] host_addr;
  logic        buf_we;
  logic [4:0]  buf_addr;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        dev_ready;
  logic [15:0] num_words;
  logic [16:0] start_addr;
  logic        rd_wr;
  logic        rqst;
  logic        dev_ack;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic [15:0] dev_out;
  logic        end_flag;

  int n_chk  = 0;
  int n_fail = 0;
  int rqst_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  dma_dev_agent dut (
    .clk        (clk),
    .reset      (reset),
    .host_start (host_start),
    .host_dir   (host_dir),
    .host_words (host_words),
    .host_addr  (host_addr),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_rdata  (buf_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .dev_ready  (dev_ready),
    .num_words  (num_words),
    .start_addr (start_addr),
    .rd_wr      (rd_wr),
    .rqst       (rqst),
    .dev_ack    (dev_ack),
    .dev_in     (dev_in),
    .dma_ack    (dma_ack),
    .dev_out    (dev_out),
    .end_flag   (end_flag)
  );

  always @(negedge clk) begin
    if (rqst === 1'b1) rqst_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic        dir;
    logic [15:0] words;
    logic [16:0] addr;
    int          nbeats;
    bit          end_last;
    logic [1:0]  code;
  } rec_t;

  rec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_w(int i);
    return 16'((i + 1) * 16'h1111);
  endfunction

  function automatic logic [15:0] pat(int i);
    return 16'(16'hA0A0 + i * 16'h1010);
  endfunction

  task automatic load_buf();
    for (int i = 0; i < 32; i++) begin
      buf_we    = 1'b1;
      buf_addr  = 5'(i);
      buf_wdata = init_w(i);
      tick();
    end
    buf_we = 1'b0;
  endtask

  task automatic run_rec(input rec_t r);
    logic bad;
    int   lim;
    load_buf();
    rqst_cnt = 0;
    bad = (r.words == 0) || (r.words > 32);
    host_dir   = r.dir;
    host_words = r.words;
    host_addr  = r.addr;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    if (!bad) begin
      check("req_rqst", 32'(rqst), 1);
      check("req_addr", 32'(start_addr), 32'(r.addr));
      check("req_words", 32'(num_words), 32'(r.words));
      check("req_dir", 32'(rd_wr), 32'(r.dir));
      tick();
      check("xfer_rqst_low", 32'(rqst), 0);
      check("xfer_dev_ack", 32'(dev_ack), 1);
      for (int i = 0; i < r.nbeats; i++) begin
        dma_ack  = 1'b1;
        dev_out  = pat(i);
        end_flag = r.end_last && (i == r.nbeats - 1);
        #3;
        if (!r.dir && i < r.words)
          check("dev_in", 32'(dev_in), 32'(init_w(i)));
        tick();
      end
      dma_ack = 1'b0;
      if (!r.end_last) begin
        end_flag = 1'b1;
        tick();
      end
      end_flag = 1'b0;
    end
    check("end_done", 32'(done), 1);
    check("end_err", 32'(err), 32'(r.code != 0));
    check("end_code", 32'(err_code), 32'(r.code));
    tick();
    check("post_done_low", 32'(done), 0);
    check("post_busy_low", 32'(busy), 0);
    check("post_err_held", 32'(err), 32'(r.code != 0));
    check("rqst_pulses", rqst_cnt, bad ? 0 : 1);
    if (r.dir && !bad) begin
      lim = (r.nbeats > r.words) ? r.nbeats
                                 : int'(r.words);
      if (lim > 32) lim = 32;
      for (int i = 0; i < lim; i++) begin
        buf_addr = 5'(i);
        #1;
        check("buf_word", 32'(buf_rdata),
              (i < r.words && i < r.nbeats)
                ? 32'(pat(i)) : 32'(init_w(i)));
      end
    end
  endtask

  initial begin
    int n;
    int dc;
    tbl[0] = '{1'b0, 16'd4,  17'h0200, 4,  1'b0, 2'd0};
    tbl[1] = '{1'b1, 16'd3,  17'h0010, 3,  1'b0, 2'd0};
    tbl[2] = '{1'b0, 16'd0,  17'h0300, 0,  1'b0, 2'd1};
    tbl[3] = '{1'b1, 16'd33, 17'h0300, 0,  1'b0, 2'd1};
    tbl[4] = '{1'b1, 16'd32, 17'h1000, 32, 1'b0, 2'd0};
    tbl[5] = '{1'b1, 16'd4,  17'h0020, 2,  1'b0, 2'd3};
    tbl[6] = '{1'b1, 16'd4,  17'h0020, 5,  1'b0, 2'd3};
    tbl[7] = '{1'b0, 16'd2,  17'h1FFFE, 2, 1'b1, 2'd0};
    tbl[8] = '{1'b1, 16'd2,  17'h0040, 1,  1'b1, 2'd3};

    reset = 1'b1;
    host_start = 1'b0; host_dir = 1'b0;
    host_words = '0;   host_addr = '0;
    buf_we = 1'b0;     buf_addr = '0;
    buf_wdata = '0;    dev_ready = 1'b1;
    dma_ack = 1'b0;    dev_out = '0;
    end_flag = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_rqst", 32'(rqst), 0);
    check("rst_dev_ack", 32'(dev_ack), 0);
    check("rst_num_words", 32'(num_words), 0);
    check("rst_start_addr", 32'(start_addr), 0);
    check("rst_dev_in", 32'(dev_in), 0);
    reset = 1'b0;
    tick();

    foreach (tbl[k]) run_rec(tbl[k]);

    // Stall mid-read, with ignored start/write.
    load_buf();
    host_dir = 1'b1; host_words = 16'd3;
    host_addr = 17'h0080; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    dma_ack = 1'b1; dev_out = pat(0);
    tick();
    dma_ack = 1'b0; dev_ready = 1'b0;
    host_start = 1'b1; host_words = 16'd7;
    buf_we = 1'b1; buf_addr = 5'd5;
    buf_wdata = 16'hDEAD;
    #1;
    check("stall_dev_ack_0", 32'(dev_ack), 0);
    tick();
    host_start = 1'b0; buf_we = 1'b0;
    check("stall_dev_ack_1", 32'(dev_ack), 0);
    check("busy_start_ignored", 32'(num_words), 3);
    tick();
    dev_ready = 1'b1;
    #1;
    check("stall_resume", 32'(dev_ack), 1);
    for (int i = 1; i < 3; i++) begin
      dma_ack = 1'b1; dev_out = pat(i);
      tick();
    end
    dma_ack = 1'b0; end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("stall_done", 32'(done), 1);
    check("stall_code", 32'(err_code), 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      buf_addr = 5'(i);
      #1;
      check("stall_buf", 32'(buf_rdata), 32'(pat(i)));
    end
    buf_addr = 5'd5;
    #1;
    check("busy_we_ignored", 32'(buf_rdata),
          32'(init_w(5)));

    // Silent controller: watchdog expiry.
    host_dir = 1'b0; host_words = 16'd2;
    host_addr = 17'h0100; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    check("to_dev_ack", 32'(dev_ack), 1);
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check("to_cycles", n, 4095);
    check("to_code", 32'(err_code), 2);
    check("to_err", 32'(err), 1);
    check("to_dev_ack_low", 32'(dev_ack), 0);
    tick();

    // Reset in the middle of a transfer.
    host_dir = 1'b0; host_words = 16'd3;
    host_addr = 17'h0100; host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    dc = done_cnt;
    reset = 1'b1;
    #1;
    check("mrst_rqst", 32'(rqst), 0);
    check("mrst_dev_ack", 32'(dev_ack), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_words", 32'(num_words), 0);
    check("mrst_addr", 32'(start_addr), 0);
    check("mrst_dev_in", 32'(dev_in), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mrst_no_done", done_cnt, dc);
    run_rec(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
